// File: rtl/io_bank_cfg_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : io_bank_cfg_pkg
// Purpose  : Shared types and constants for the IO bank configuration
//            sequencer: sequencer state encoding, the per-pad 3-bit
//            configuration word, pad safe values and small helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package io_bank_cfg_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_SAFE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PULL   = 3'd2,
    ST_INEN   = 3'd3,
    ST_ACTIVE = 3'd4
  } state_t;

  // Per-pad configuration word, MSB first on cfg_data
  typedef struct packed {
    logic use_output;
    logic pull_en;
    logic input_en;
  } cfg_word_t;

  // Per-bit pad values that keep a pad harmless (driver off, pull off,
  // input buffer off, boundary scan off)
  localparam logic c_safe_do   = 1'b0;
  localparam logic c_safe_oen  = 1'b1;
  localparam logic c_safe_ren  = 1'b1;
  localparam logic c_safe_ie   = 1'b0;
  localparam logic c_safe_bsen = 1'b0;

  // Width of the pull settle down-counter
  localparam int c_timer_w = 8;

  // Pad index width; a single-pad bank still needs a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : io_bank_cfg_pkg
`default_nettype wire

// File: rtl/io_settle_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : io_settle_timer
// Purpose  : 8-bit down-counter used to hold the pull-settle phase.
//            A load pulse arms the counter with load_val; done is high for
//            the single cycle in which the armed counter sits at zero.
// Ports    : clk, rst (async, active-high)
//            load      in   arm counter with load_val
//            load_val  in   start value (cycles - 1)
//            done      out  one-cycle pulse when count expires
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module io_settle_timer
  import io_bank_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [c_timer_w-1:0] load_val,
  output logic                 done
);

  logic [c_timer_w-1:0] r_count;
  logic                 r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - c_timer_w'(1);
      end
    end
  end

  // Armed and expired: a load value of N-1 yields exactly N busy cycles
  assign done = r_busy && (r_count == '0);

endmodule : io_settle_timer
`default_nettype wire

// File: rtl/io_bank_cfg_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : io_bank_cfg_ctrl
// Purpose  : Power-up / reconfiguration sequencer for one GPIO pad bank.
//            Holds pads safe, loads one 3-bit word per pad over valid/ready,
//            then enables pulls, waits PULL_SETTLE cycles, enables inputs,
//            and finally hands output data/enable to the fabric.
// Ports    : clk, rst (async, active-high)
//            cfg_start            restart request (SAFE / ACTIVE only)
//            cfg_valid/cfg_ready  config word handshake
//            cfg_data             {use_output, pull_en, input_en}
//            core_do/core_oe      fabric data / output enable
//            pad_DO/OEN/REN/IE/BSEN  registered pad control pins
//            cfg_done             bank is operational
// Options  : IO_BSCAN_EN adds bscan_mode/bscan_do/bscan_oe, which override
//            the output path in ACTIVE; otherwise pad_BSEN is tied low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module io_bank_cfg_ctrl
  import io_bank_cfg_pkg::*;
#(
  parameter int NUM_PADS    = 8,
  parameter int PULL_SETTLE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_data,
  input  logic [NUM_PADS-1:0] core_do,
  input  logic [NUM_PADS-1:0] core_oe,
`ifdef IO_BSCAN_EN
  input  logic                bscan_mode,
  input  logic [NUM_PADS-1:0] bscan_do,
  input  logic [NUM_PADS-1:0] bscan_oe,
`endif
  output logic [NUM_PADS-1:0] pad_DO,
  output logic [NUM_PADS-1:0] pad_OEN,
  output logic [NUM_PADS-1:0] pad_REN,
  output logic [NUM_PADS-1:0] pad_IE,
  output logic [NUM_PADS-1:0] pad_BSEN,
  output logic                cfg_done
);

  localparam int                   c_idx_w       = idx_width(NUM_PADS);
  localparam logic [c_idx_w-1:0]   c_last_idx    = c_idx_w'(NUM_PADS - 1);
  localparam logic [c_timer_w-1:0] c_settle_load = c_timer_w'(PULL_SETTLE - 1);

  state_t               r_state, w_next_state;
  logic [c_idx_w-1:0]   r_idx;
  cfg_word_t            r_cfg [NUM_PADS];
  logic                 r_restart;
  logic                 r_cfg_ready;
  logic                 r_cfg_done;
  logic [NUM_PADS-1:0]  r_pad_do, r_pad_oen, r_pad_ren, r_pad_ie;

  logic                 w_accept, w_last_word, w_leave_active, w_timer_done;
  logic [NUM_PADS-1:0]  w_use_output, w_pull_en, w_input_en;
  logic [NUM_PADS-1:0]  w_act_do, w_act_oen;

  assign w_accept       = cfg_valid & r_cfg_ready;
  assign w_last_word    = w_accept & (r_idx == c_last_idx);
  assign w_leave_active = (r_state == ST_ACTIVE) & cfg_start;

  // Flatten stored words into per-field bank vectors
  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    assign w_use_output[k] = r_cfg[k].use_output;
    assign w_pull_en[k]    = r_cfg[k].pull_en;
    assign w_input_en[k]   = r_cfg[k].input_en;
  end

  io_settle_timer u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (w_last_word),
    .load_val (c_settle_load),
    .done     (w_timer_done)
  );

  //--------------------------------------------------------------------------
  // Sequencer
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      // r_restart carries a reconfigure request out of ACTIVE through the
      // one mandatory SAFE cycle without needing a second cfg_start
      ST_SAFE:   if (cfg_start || r_restart) w_next_state = ST_LOAD;
      ST_LOAD:   if (w_last_word)            w_next_state = ST_PULL;
      ST_PULL:   if (w_timer_done)           w_next_state = ST_INEN;
      ST_INEN:                               w_next_state = ST_ACTIVE;
      ST_ACTIVE: if (cfg_start)              w_next_state = ST_SAFE;
      default:                               w_next_state = ST_SAFE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SAFE;
      r_restart   <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_restart   <= w_leave_active;
      // Decoded from the next state so ready lines up exactly with LOAD
      r_cfg_ready <= (w_next_state == ST_LOAD);
    end
  end

  //--------------------------------------------------------------------------
  // Configuration store
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int k = 0; k < NUM_PADS; k++) r_cfg[k] <= '0;
    end else if (w_accept) begin
      r_cfg[r_idx] <= cfg_word_t'(cfg_data);
      r_idx        <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);
    end
  end

  //--------------------------------------------------------------------------
  // Pad drive
  //--------------------------------------------------------------------------
`ifdef IO_BSCAN_EN
  logic [NUM_PADS-1:0] r_pad_bsen;

  assign w_act_do  = bscan_mode ? bscan_do  : (core_do & w_use_output);
  assign w_act_oen = bscan_mode ? ~bscan_oe : ~(w_use_output & core_oe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_bsen <= {NUM_PADS{c_safe_bsen}};
    end else begin
      r_pad_bsen <= {NUM_PADS{(r_state == ST_ACTIVE) & ~cfg_start & bscan_mode}};
    end
  end

  assign pad_BSEN = r_pad_bsen;
`else
  assign w_act_do  = core_do & w_use_output;
  assign w_act_oen = ~(w_use_output & core_oe);
  assign pad_BSEN  = {NUM_PADS{c_safe_bsen}};
`endif

  // Outputs lag the state by one register stage; leaving ACTIVE bypasses
  // that lag so the pads are safe on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_do   <= {NUM_PADS{c_safe_do}};
      r_pad_oen  <= {NUM_PADS{c_safe_oen}};
      r_pad_ren  <= {NUM_PADS{c_safe_ren}};
      r_pad_ie   <= {NUM_PADS{c_safe_ie}};
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_done <= (r_state == ST_ACTIVE) & ~cfg_start;
      if (w_leave_active) begin
        r_pad_do  <= {NUM_PADS{c_safe_do}};
        r_pad_oen <= {NUM_PADS{c_safe_oen}};
        r_pad_ren <= {NUM_PADS{c_safe_ren}};
        r_pad_ie  <= {NUM_PADS{c_safe_ie}};
      end else begin
        case (r_state)
          ST_PULL:   r_pad_ren <= ~w_pull_en;
          ST_INEN:   r_pad_ie  <= w_input_en;
          ST_ACTIVE: begin
            r_pad_do  <= w_act_do;
            r_pad_oen <= w_act_oen;
          end
          default: begin
            r_pad_do  <= {NUM_PADS{c_safe_do}};
            r_pad_oen <= {NUM_PADS{c_safe_oen}};
            r_pad_ren <= {NUM_PADS{c_safe_ren}};
            r_pad_ie  <= {NUM_PADS{c_safe_ie}};
          end
        endcase
      end
    end
  end

  assign pad_DO    = r_pad_do;
  assign pad_OEN   = r_pad_oen;
  assign pad_REN   = r_pad_ren;
  assign pad_IE    = r_pad_ie;
  assign cfg_ready = r_cfg_ready;
  assign cfg_done  = r_cfg_done;

endmodule : io_bank_cfg_ctrl
`default_nettype wire

// File: doc/io_bank_cfg_ctrl.md
# io_bank_cfg_ctrl

Power-up and reconfiguration sequencer for one bank of UMC40 GPIO pad cells. The block holds every pad in a safe state out of reset, loads a per-pad configuration word over a valid/ready stream, then drives the pad control pins (DO, OEN, REN, IE, BSEN) in a fixed order: pulls first, then inputs, then outputs. It sits between the fabric/config logic and the pad ring, one instance per IO bank.

## Interface
Parameters:
- NUM_PADS, 8, number of pads in the bank (1..32)
- PULL_SETTLE, 16, cycles to wait after pull enable before input enable (1..255)

Ports:
- clk  input  1  bank clock
- rst  input  1  asynchronous, active-high reset
- cfg_start  input  1  single-cycle request to (re)configure the bank
- cfg_valid  input  1  config word valid
- cfg_ready  output  1  block accepts a config word
- cfg_data  input  3  {use_output, pull_en, input_en} for the current pad
- core_do  input  NUM_PADS  fabric output data
- core_oe  input  NUM_PADS  fabric output enable, active-high
- pad_DO  output  NUM_PADS  to pad DO
- pad_OEN  output  NUM_PADS  to pad OEN, active-low
- pad_REN  output  NUM_PADS  to pad REN, active-low pull enable
- pad_IE  output  NUM_PADS  to pad IE
- pad_BSEN  output  NUM_PADS  to pad BSEN
- cfg_done  output  1  bank is in ACTIVE

## Operation
- States: SAFE, LOAD, PULL, INEN, ACTIVE.
- SAFE: pad_OEN all 1, pad_REN all 1, pad_IE all 0, pad_DO all 0, pad_BSEN all 0. cfg_start -> LOAD.
- LOAD: cfg_ready=1; each accepted word (valid & ready) is stored for pad index idx, idx increments 0..NUM_PADS-1; after the word for NUM_PADS-1 -> PULL. Pads stay safe during LOAD.
- PULL: pad_REN[k] = ~pull_en[k]; settle counter loaded with PULL_SETTLE-1, counts to 0 -> INEN.
- INEN: pad_IE[k] = input_en[k]; exactly 1 cycle -> ACTIVE.
- ACTIVE: pad_OEN[k] = ~(use_output[k] & core_oe[k]); pad_DO[k] = core_do[k] & use_output[k]; cfg_done=1. cfg_start -> SAFE for one cycle, then LOAD.
- cfg_start in LOAD, PULL or INEN is ignored; words arriving outside LOAD are not accepted (cfg_ready=0).
- REN and IE values persist from PULL/INEN through ACTIVE; they return to safe values on entry to SAFE.

## Timing
- Reset: state SAFE, idx=0, counter=0, stored config all 0, cfg_ready=0, cfg_done=0, pad outputs at SAFE values. Reset asserted mid-sequence forces all outputs safe immediately (asynchronous).
- All pad outputs and cfg_ready/cfg_done are registered; core_do/core_oe reach pad pins 1 cycle later.
- Handshake: cfg_ready is a registered state decode; cfg_valid may stay high across words; one word per cycle max.
- Sequence latency from last LOAD word: PULL entered next cycle, PULL lasts exactly PULL_SETTLE cycles, INEN 1 cycle, cfg_done high PULL_SETTLE+2 cycles after the last handshake.
- cfg_start in ACTIVE: next cycle all outputs safe and cfg_done=0; cfg_ready=1 the cycle after.
- idx width = clog2(NUM_PADS) (min 1); no wrap past NUM_PADS-1.

## Configuration
- IO_BSCAN_EN defined: adds inputs bscan_mode (1), bscan_do (NUM_PADS), bscan_oe (NUM_PADS). In ACTIVE with bscan_mode=1, pad_BSEN all 1, pad_DO = bscan_do, pad_OEN = ~bscan_oe, ignoring use_output and core signals; registered, 1-cycle latency. bscan_mode ignored in other states.
- Not defined: ports absent, pad_BSEN tied 0.

## Structure
- Package io_bank_cfg_pkg: state enum, 3-bit config word struct (use_output, pull_en, input_en), safe-value constants.
- Sub-module io_settle_timer: 8-bit down-counter, load/start input, done pulse.

## Test plan
- Reset then no cfg_start for 50 cycles -> OEN all 1, REN all 1, IE 0, DO 0, cfg_ready 0, cfg_done 0.
- NUM_PADS=8, PULL_SETTLE=16, cfg_start then 8 words 3'b111 back-to-back -> REN all 0 one cycle after 8th word, IE all 1 after 16 more cycles, cfg_done after 18 cycles; core_oe=8'hFF, core_do=8'hA5 -> pad_DO=8'hA5, pad_OEN=0 next cycle.
- Words with cfg_valid gapped (every 3rd cycle) -> only 8 words accepted, idx mapping correct (pad 3 word 3'b001 -> pad 3 input-only, OEN stays 1 with core_oe=1).
- cfg_start in ACTIVE -> next cycle all outputs safe, cfg_done 0, then reload new words; cfg_start during PULL -> ignored.
- rst asserted mid-PULL -> outputs safe immediately without clock edge; restart completes normally.
- IO_BSCAN_EN: ACTIVE, bscan_mode=1, bscan_do=8'h0F, bscan_oe=8'hF0 -> BSEN all 1, pad_DO=8'h0F, pad_OEN=8'h0F.
